// File: rtl/vic_prio_wb.sv
// Vectored interrupt controller: N sources with edge/level mode, a runtime mask and a
// spurious vector. Define VIC_ROTATE_EN to get round-robin instead of fixed priority.
module vic_prio_wb #(
  parameter int            N         = 4,
  parameter logic [N-1:0]  EDGE      = {N{1'b1}},
  parameter logic [N-1:0]  MASK_INIT = {N{1'b1}},
  parameter logic [15:0]   SPUR_VEC  = 16'o000000
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce,
  input  logic [16*N-1:0] ivec,
  input  logic [N-1:0]    ireq,
  output logic [N-1:0]    iack,
  input  logic            mask_we,
  input  logic [N-1:0]    mask_din,
  output logic [N-1:0]    mask_q,
  output logic [N-1:0]    pending_q,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  output logic [15:0]     wb_dat_o,
  output logic            wb_irq_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, REPLY, HOLD} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   ireq_prev_q;
  logic [N-1:0]   pending_d;
  logic [N-1:0]   iack_q, iack_d;
  logic           ack_q, ack_d;
  logic [15:0]    dat_q, dat_d;
  logic           irq_q;
  logic [N-1:0]   req;
  logic [IW-1:0]  sel_idx;
  logic           sel_vld;

  assign req      = pending_q & mask_q;
  assign sel_vld  = |req;
  assign iack     = iack_q;
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign wb_irq_o = irq_q;

`ifdef VIC_ROTATE_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Later iterations overwrite earlier ones, so ptr-1 ends up with the highest rank.
  always_comb begin
    int idx;
    idx     = 0;
    sel_idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr_q) + N - k) % N;
      if (req[idx]) sel_idx = IW'(idx);
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) sel_idx = IW'(i);
    end
  end
`endif

  // Acknowledge FSM: the vector is captured on IDLE exit and frozen until back in IDLE.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    dat_d   = dat_q;
    iack_d  = '0;
`ifdef VIC_ROTATE_EN
    ptr_d   = ptr_q;
`endif
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (wb_stb_i) begin
            ack_d   = 1'b1;
            dat_d   = sel_vld ? ivec[int'(sel_idx)*16 +: 16] : SPUR_VEC;
            state_d = REPLY;
            if (sel_vld) begin
              iack_d[sel_idx] = 1'b1;
`ifdef VIC_ROTATE_EN
              ptr_d = sel_idx;
`endif
            end
          end
        end
        REPLY: state_d = HOLD;
        HOLD: begin
          if (!wb_stb_i) begin
            ack_d   = 1'b0;
            dat_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Edge channels: a new rising edge beats a simultaneous acknowledge clear.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N; i++) begin
      if (EDGE[i])
        pending_d[i] = (ireq[i] & ~ireq_prev_q[i]) | (pending_q[i] & ~iack_d[i]);
      else
        pending_d[i] = ireq[i];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ireq_prev_q <= '0;
      pending_q   <= '0;
      mask_q      <= MASK_INIT;
      iack_q      <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      irq_q       <= 1'b0;
`ifdef VIC_ROTATE_EN
      ptr_q       <= IW'(N - 1);
`endif
    end else begin
      state_q     <= state_d;
      ireq_prev_q <= ireq;
      pending_q   <= pending_d;
      if (mask_we) mask_q <= mask_din;
      iack_q      <= iack_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      irq_q       <= |(pending_q & mask_q);
`ifdef VIC_ROTATE_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_vic_prio_wb.sv
// Directed bench for vic_prio_wb: N=4, channel 0 level-sensitive, channels 1..3 edge.
module tb_vic_prio_wb;

  localparam int N = 4;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic            ce;
  logic [16*N-1:0] ivec;
  logic [N-1:0]    ireq;
  logic [N-1:0]    iack;
  logic            mask_we;
  logic [N-1:0]    mask_din;
  logic [N-1:0]    mask_q;
  logic [N-1:0]    pending_q;
  logic            wb_stb_i;
  logic            wb_ack_o;
  logic [15:0]     wb_dat_o;
  logic            wb_irq_o;

  int n_chk = 0;
  int n_err = 0;

  vic_prio_wb #(
    .N(N), .EDGE(4'b1110), .MASK_INIT(4'b1111), .SPUR_VEC(16'o000000)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .ivec(ivec), .ireq(ireq), .iack(iack),
    .mask_we(mask_we), .mask_din(mask_din), .mask_q(mask_q), .pending_q(pending_q),
    .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .wb_irq_o(wb_irq_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o expected %0o", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_ack(input string tag, input logic [15:0] exp_dat, input logic [N-1:0] exp_iack);
    wb_stb_i = 1'b1;
    tick();
    check({tag, "_ack"}, wb_ack_o, 1'b1);
    check({tag, "_dat"}, wb_dat_o, exp_dat);
    check({tag, "_iack"}, iack, exp_iack);
    tick();
    check({tag, "_iack_one_clk"}, iack, '0);
    check({tag, "_hold_ack"}, wb_ack_o, 1'b1);
    wb_stb_i = 1'b0;
    tick();
    check({tag, "_drop_ack"}, wb_ack_o, 1'b0);
    check({tag, "_drop_dat"}, wb_dat_o, 16'd0);
  endtask

  initial begin
    reset    = 1'b1;
    ce       = 1'b1;
    ivec     = {16'o000274, 16'o000060, 16'o000100, 16'o000104};
    ireq     = '0;
    mask_we  = 1'b0;
    mask_din = '0;
    wb_stb_i = 1'b0;
    tick();
    tick();
    check("rst_ack", wb_ack_o, 1'b0);
    check("rst_dat", wb_dat_o, 16'd0);
    check("rst_irq", wb_irq_o, 1'b0);
    check("rst_pend", pending_q, 4'b0000);
    check("rst_mask", mask_q, 4'b1111);
    check("rst_iack", iack, 4'b0000);
    reset = 1'b0;

    // ch2 edge pulse plus ch0 level held: ch2 wins first, then ch0
    ireq = 4'b0101;
    tick();
    ireq = 4'b0001;
    tick();
    check("prio_pend", pending_q, 4'b0101);
    check("prio_irq", wb_irq_o, 1'b1);
    do_ack("prio_ch2", 16'o000060, 4'b0100);
    do_ack("prio_ch0", 16'o000104, 4'b0001);
    check("level_pend_kept", pending_q, 4'b0001);
    check("level_irq_kept", wb_irq_o, 1'b1);
    ireq = 4'b0000;
    tick();
    tick();
    check("level_irq_drop", wb_irq_o, 1'b0);

    // masked channel still latches pending
    mask_we = 1'b1; mask_din = 4'b1011;
    tick();
    mask_we = 1'b0;
    check("mask_val", mask_q, 4'b1011);
    ireq = 4'b0100;
    tick();
    ireq = 4'b0000;
    tick();
    tick();
    check("mask_irq_off", wb_irq_o, 1'b0);
    check("mask_pend", pending_q, 4'b0100);
    mask_we = 1'b1; mask_din = 4'b1111;
    tick();
    mask_we = 1'b0;
    check("unmask_irq_lat", wb_irq_o, 1'b0);
    tick();
    check("unmask_irq", wb_irq_o, 1'b1);
    do_ack("unmask_ch2", 16'o000060, 4'b0100);

    // withdrawn level request while ce is low gives the spurious vector
    ce = 1'b0; wb_stb_i = 1'b1; ireq = 4'b0001;
    tick();
    ireq = 4'b0000;
    tick();
    check("ce_gate_ack", wb_ack_o, 1'b0);
    ce = 1'b1;
    tick();
    check("spur_ack", wb_ack_o, 1'b1);
    check("spur_dat", wb_dat_o, 16'o000000);
    check("spur_iack", iack, 4'b0000);
    tick();
    wb_stb_i = 1'b0;
    tick();
    check("spur_drop", wb_ack_o, 1'b0);

    // reset while in HOLD with ch1 still pending and a fresh mask value
    ireq = 4'b1000;
    tick();
    ireq = 4'b0010;
    tick();
    ireq = 4'b0000;
    wb_stb_i = 1'b1;
    tick();
    check("abort_dat", wb_dat_o, 16'o000274);
    check("abort_iack", iack, 4'b1000);
    tick();
    mask_we = 1'b1; mask_din = 4'b0001;
    tick();
    mask_we = 1'b0;
    check("abort_pend_before", pending_q, 4'b0010);
    check("abort_hold_ack", wb_ack_o, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_ack", wb_ack_o, 1'b0);
    check("abort_dat0", wb_dat_o, 16'd0);
    check("abort_pend", pending_q, 4'b0000);
    check("abort_mask", mask_q, 4'b1111);
    check("abort_iack0", iack, 4'b0000);
    wb_stb_i = 1'b0;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    ireq = 4'b1000;
    tick();
    ireq = 4'b0000;
    tick();
    do_ack("post_rst", 16'o000274, 4'b1000);

`ifdef VIC_ROTATE_EN
    ireq = 4'b1000;
    tick();
    ireq = 4'b0000;
    tick();
    do_ack("rr0_ch3", 16'o000274, 4'b1000);
    for (int r = 1; r < 4; r++) begin
      ireq = 4'b1010;
      tick();
      ireq = 4'b0000;
      tick();
      if (r % 2 == 1) do_ack("rr_ch1", 16'o000100, 4'b0010);
      else            do_ack("rr_ch3", 16'o000274, 4'b1000);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
